// File: rtl/i2c_slave.sv
// I2C target with an 8 x 8-bit register file behind a byte pointer.
// SCL/SDA are oversampled on CLOCK; SDA is open-drain (drives 0 or Z only).
module i2c_slave #(
    parameter logic [7:0] I2C_SLAVE_ADDR = 8'h78
) (
    input  logic CLOCK,
    input  logic RESET,
    inout  wire  SDA,
    input  logic SCL
);

    // state      | meaning
    // IDLE       | bus ignored until a START
    // ADDR       | shifting in the address byte
    // ADDR_ACK   | driving ACK for the address byte
    // REG        | shifting in the register pointer
    // REG_ACK    | driving ACK for the pointer byte
    // WDATA      | shifting in a write data byte
    // WDATA_ACK  | driving ACK for a write data byte
    // RDATA      | driving a read data byte, MSB first
    // RDATA_ACK  | SDA released, sampling the master ACK/NACK
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    state_t state, state_next;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [6:0] rx;
    logic [7:0] tx;
    logic       rw;
    logic [7:0] ptr;
    logic [7:0] regs [8];

    logic       shifting;
    logic [7:0] rx_byte;
    logic [7:0] rd_byte;
    logic       addr_match;
    logic       sda_low;

    // Synchronisers reset to the idle-bus level so no false edge appears
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

    assign shifting   = (state == ADDR) || (state == REG) || (state == WDATA);
    assign rx_byte    = {rx, sda_s2};
    assign rd_byte    = (ptr[7:3] == 5'd0) ? regs[ptr[2:0]] : 8'h00;
    assign addr_match = (rx == I2C_SLAVE_ADDR[7:1]);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = ADDR;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                ADDR: begin
                    if (scl_rise && !byte_done && bit_cnt == 3'd7 && !addr_match)
                        state_next = IDLE;
                    else if (scl_fall && byte_done)
                        state_next = ADDR_ACK;
                end
                ADDR_ACK: begin
                    if (scl_fall)
                        state_next = rw ? RDATA : REG;
                end
                REG: begin
                    if (scl_fall && byte_done)
                        state_next = REG_ACK;
                end
                REG_ACK: begin
                    if (scl_fall)
                        state_next = WDATA;
                end
                WDATA: begin
                    if (scl_fall && byte_done)
                        state_next = WDATA_ACK;
                end
                WDATA_ACK: begin
                    if (scl_fall)
                        state_next = WDATA;
                end
                RDATA: begin
                    if (scl_fall && byte_done)
                        state_next = RDATA_ACK;
                end
                RDATA_ACK: begin
                    if (scl_rise && sda_s2)
                        state_next = IDLE;
                    else if (scl_fall)
                        state_next = RDATA;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        sda_low = 1'b0;
        case (state)
            ADDR_ACK, REG_ACK, WDATA_ACK: sda_low = 1'b1;
            RDATA:                        sda_low = ~tx[7];
            default:                      sda_low = 1'b0;
        endcase
    end

    assign SDA = sda_low ? 1'b0 : 1'bz;

    // Bit counting, byte capture, pointer and register file
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            rx        <= 7'd0;
            tx        <= 8'd0;
            rw        <= 1'b0;
            ptr       <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (start_det) begin
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
        end else if (scl_rise) begin
            if ((shifting || state == RDATA) && !byte_done) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (shifting)
                    rx <= {rx[5:0], sda_s2};
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    case (state)
                        ADDR: rw <= sda_s2;
                        REG:  ptr <= rx_byte;
                        WDATA: begin
                            if (ptr[7:3] == 5'd0)
                                regs[ptr[2:0]] <= rx_byte;
                            ptr <= ptr + 8'd1;
                        end
                        default: ;
                    endcase
                end
            end else if (state == RDATA_ACK && !sda_s2) begin
                ptr <= ptr + 8'd1;
            end
        end else if (scl_fall) begin
            if (byte_done) begin
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
            end else if (state == RDATA) begin
                tx <= {tx[6:0], 1'b0};
            end
            // Next read byte is loaded as the ACK slot closes so bit 7 drives at once
            if ((state == ADDR_ACK && rw) || state == RDATA_ACK)
                tx <= rd_byte;
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master with an SDA pull-up, and a
// byte-level register-file model that predicts every ACK and read byte.
`timescale 1ns/100ps
module tb_i2c_slave;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst;
    logic scl;
    logic m_sda_low;
    wire  sda;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave #(.I2C_SLAVE_ADDR(8'h78)) dut (
        .CLOCK(clk),
        .RESET(rst),
        .SDA(sda),
        .SCL(scl)
    );

    always #1 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic bus_level;

    logic [7:0] m_regs [8];
    int m_ptr;
    logic [7:0] buf_data [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(2 * Q);
        m_sda_low = 1'b1;
        wait_clks(2 * Q);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clks(Q);
        m_sda_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(2 * Q);
        m_sda_low = 1'b0;
        wait_clks(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        wait_clks(Q);
        m_sda_low = ~b;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        bus_level = sda;
        wait_clks(Q);
        scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clks(Q);
        m_sda_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        b = sda;
        wait_clks(Q);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            b[i] = bt;
        end
        write_bit(nack);
    endtask

    task automatic wr_txn(input int p, input int n);
        logic a;
        bus_start();
        write_byte(8'h78, a);
        check("wr_addr_ack", {31'd0, a}, 32'd0);
        write_byte(p[7:0], a);
        check("wr_ptr_ack", {31'd0, a}, 32'd0);
        m_ptr = p;
        for (int i = 0; i < n; i++) begin
            write_byte(buf_data[i], a);
            check($sformatf("wr_data_ack[%0d]", i), {31'd0, a}, 32'd0);
            if (m_ptr < 8) m_regs[m_ptr] = buf_data[i];
            m_ptr = (m_ptr + 1) % 256;
        end
        bus_stop();
    endtask

    task automatic rd_txn(input int p, input int n, input logic set_ptr);
        logic a;
        logic [7:0] d, e;
        if (set_ptr) begin
            bus_start();
            write_byte(8'h78, a);
            check("rd_addrw_ack", {31'd0, a}, 32'd0);
            write_byte(p[7:0], a);
            check("rd_ptr_ack", {31'd0, a}, 32'd0);
            m_ptr = p;
        end
        bus_start();
        write_byte(8'h79, a);
        check("rd_addrr_ack", {31'd0, a}, 32'd0);
        for (int i = 0; i < n; i++) begin
            e = (m_ptr < 8) ? m_regs[m_ptr] : 8'h00;
            read_byte(i == n - 1, d);
            check($sformatf("rd_data ptr=%0d", m_ptr), {24'd0, d}, {24'd0, e});
            if (i != n - 1) m_ptr = (m_ptr + 1) % 256;
        end
        check("rd_nack_released", {31'd0, bus_level}, 32'd1);
        bus_stop();
        check("rd_stop_released", {31'd0, sda}, 32'd1);
    endtask

    initial begin
        logic a;
        int p, n;
        rst = 1'b1;
        scl = 1'b1;
        m_sda_low = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        wait_clks(5);
        check("reset_sda_released", {31'd0, sda}, 32'd1);
        rst = 1'b0;
        wait_clks(5);

        // Pointer resets to 0 and registers to 0x00
        rd_txn(0, 2, 1'b0);

        buf_data[0] = 8'h4A;
        wr_txn(4, 1);
        buf_data[0] = 8'h6B;
        wr_txn(0, 1);
        rd_txn(0, 8, 1'b1);
        rd_txn(0, 1, 1'b1);

        // Foreign address: never ACKed, registers untouched
        bus_start();
        write_byte(8'h50, a);
        check("bad_addr_nack", {31'd0, a}, 32'd1);
        write_byte(8'h02, a);
        check("bad_addr_ptr_nack", {31'd0, a}, 32'd1);
        write_byte(8'hEE, a);
        check("bad_addr_data_nack", {31'd0, a}, 32'd1);
        bus_stop();
        rd_txn(0, 8, 1'b1);

        buf_data[0] = 8'hA1;
        buf_data[1] = 8'hB2;
        buf_data[2] = 8'hC3;
        wr_txn(6, 3);
        rd_txn(6, 3, 1'b1);

        // Reset while the slave is driving bit 7 (0) of reg[0] = 0x6B
        bus_start();
        write_byte(8'h78, a);
        check("rst_addr_ack", {31'd0, a}, 32'd0);
        write_byte(8'h00, a);
        check("rst_ptr_ack", {31'd0, a}, 32'd0);
        bus_start();
        write_byte(8'h79, a);
        check("rst_addrr_ack", {31'd0, a}, 32'd0);
        wait_clks(Q);
        check("rst_pre_drive_low", {31'd0, sda}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_sda_released", {31'd0, sda}, 32'd1);
        wait_clks(3);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        wait_clks(Q);
        rd_txn(0, 8, 1'b1);
        buf_data[0] = 8'h5C;
        wr_txn(2, 1);
        rd_txn(2, 1, 1'b1);

        // Random writes and reads, including pointers past the register file
        for (int k = 0; k < 4; k++) begin
            p = $urandom_range(0, 9);
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) buf_data[i] = 8'($urandom);
            wr_txn(p, n);
        end
        for (int k = 0; k < 3; k++) begin
            rd_txn($urandom_range(0, 9), $urandom_range(1, 4), 1'b1);
        end

        // Pointer persists: read continues where the last write left off
        buf_data[0] = 8'($urandom);
        wr_txn(3, 1);
        rd_txn(0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
